// File: rtl/cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cmd_ctrl                                                      |
// | Purpose  : Host-command controller. Parses ASCII frames from the UART RX |
// |            byte stream, drives the measurement-path configuration        |
// |            registers, gates the phase-measurement strobe into the report |
// |            engine and generates a timed PPS re-phase window.             |
// | Ports    : i_clk, i_rst       - clock, synchronous active-high reset     |
// |            i_rx_data/i_rx_den - received byte and its valid strobe       |
// |            i_ph_en            - phase-measurement result-ready strobe    |
// |            o_tx_start         - report-engine start strobe               |
// |            o_pps_ofs          - PPS offset (10 ns units)                 |
// |            o_ch_mask          - PPS1..PPS4 report enables                |
// |            o_rpt_div          - one report per (N+1) i_ph_en strobes     |
// |            o_resync           - PPS re-phase window (level)              |
// |            o_ack / o_err      - command accepted / rejected pulses       |
// |            o_busy             - parser outside IDLE                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cmd_ctrl #(
  parameter int          TIMEOUT_CYC = 5000000,
  parameter int          RESYNC_CYC  = 55000000,
  parameter logic [27:0] OFS_RST     = 28'd0,
  parameter logic [3:0]  MASK_RST    = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_den,
  input  logic        i_ph_en,
  output logic        o_tx_start,
  output logic [27:0] o_pps_ofs,
  output logic [3:0]  o_ch_mask,
  output logic [7:0]  o_rpt_div,
  output logic        o_resync,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RS_W = $clog2(RESYNC_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RS_W-1:0] RS_LOAD = RS_W'(RESYNC_CYC - 1);

  typedef enum logic [1:0] {IDLE, ARG, DRAIN, APPLY} state_t;
  typedef enum logic [1:0] {CMD_O, CMD_M, CMD_R, CMD_Z} cmd_t;

  state_t          state;
  cmd_t            cmd;
  logic [27:0]     acc;
  logic [2:0]      dig_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [RS_W-1:0] rs_cnt;
  logic [7:0]      rpt_cnt;

  // Byte classification
  logic [7:0] upper;
  logic       is_term;
  logic       is_hex;
  logic [3:0] nibble;
  logic       is_letter;
  cmd_t       letter_cmd;
  logic [2:0] need;

  always_comb begin
    // Fold lower-case ASCII onto upper case so letters and hex digits are case-insensitive
    upper      = (i_rx_data >= 8'h61 && i_rx_data <= 8'h7A) ? (i_rx_data - 8'h20) : i_rx_data;
    is_term    = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    is_hex     = 1'b0;
    nibble     = 4'h0;
    is_letter  = 1'b1;
    letter_cmd = CMD_O;
    need       = 3'd0;

    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = i_rx_data[3:0];
    end else if (upper >= 8'h41 && upper <= 8'h46) begin
      is_hex = 1'b1;
      nibble = upper[3:0] + 4'd9;   // 'A' has low nibble 1 -> 10
    end

    case (upper)
      8'h4F:   letter_cmd = CMD_O;
      8'h4D:   letter_cmd = CMD_M;
      8'h52:   letter_cmd = CMD_R;
      8'h5A:   letter_cmd = CMD_Z;
      default: is_letter  = 1'b0;
    endcase

    case (cmd)
      CMD_O:   need = 3'd7;
      CMD_M:   need = 3'd1;
      CMD_R:   need = 3'd2;
      default: need = 3'd0;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cmd        <= CMD_O;
      acc        <= '0;
      dig_cnt    <= '0;
      to_cnt     <= '0;
      rs_cnt     <= '0;
      rpt_cnt    <= '0;
      o_tx_start <= 1'b0;
      o_pps_ofs  <= OFS_RST;
      o_ch_mask  <= MASK_RST;
      o_rpt_div  <= 8'd0;
      o_resync   <= 1'b0;
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
      o_tx_start <= 1'b0;

      // Report scheduler; an 'R' write further down overrides rpt_cnt
      if (i_ph_en) begin
        if (rpt_cnt == 8'd0) begin
          o_tx_start <= 1'b1;
          rpt_cnt    <= o_rpt_div;
        end else begin
          rpt_cnt <= rpt_cnt - 8'd1;
        end
      end

      // Resync window countdown; a 'Z' write further down restarts it
      if (o_resync) begin
        if (rs_cnt == '0) o_resync <= 1'b0;
        else              rs_cnt   <= rs_cnt - RS_W'(1);
      end

      // Inter-byte timer only runs while a frame is open
      if (i_rx_den || state == IDLE || state == APPLY) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + TO_W'(1);

      case (state)
        // Registers are written on the terminator edge; APPLY is the one-cycle
        // busy tail of an accepted command and otherwise behaves like IDLE.
        IDLE, APPLY: begin
          state <= IDLE;
          if (i_rx_den) begin
            if (is_letter) begin
              cmd     <= letter_cmd;
              acc     <= '0;
              dig_cnt <= '0;
              state   <= ARG;
            end else if (!is_term) begin
              state <= DRAIN;
            end
          end
        end

        ARG: begin
          if (i_rx_den) begin
            if (is_hex && dig_cnt < need) begin
              acc     <= {acc[23:0], nibble};
              dig_cnt <= dig_cnt + 3'd1;
            end else if (is_term && dig_cnt == need) begin
              o_ack <= 1'b1;
              state <= APPLY;
              case (cmd)
                CMD_O: o_pps_ofs <= acc;
                CMD_M: o_ch_mask <= acc[3:0];
                CMD_R: begin
                  o_rpt_div <= acc[7:0];
                  rpt_cnt   <= 8'd0;
                end
                default: begin
                  o_resync <= 1'b1;
                  rs_cnt   <= RS_LOAD;
                end
              endcase
            end else if (is_term) begin
              o_err <= 1'b1;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (to_cnt == TO_LAST) begin
            o_err <= 1'b1;
            state <= IDLE;
          end
        end

        DRAIN: begin
          if (i_rx_den) begin
            if (is_term) begin
              o_err <= 1'b1;
              state <= IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            o_err <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cmd_ctrl                                                   |
// | Purpose  : Self-checking bench for cmd_ctrl: frame table, multi-cycle    |
// |            corner sequences and a randomized run against a frame-level   |
// |            reference model.                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cmd_ctrl;
  localparam int TIMEOUT_CYC = 100;
  localparam int RESYNC_CYC  = 20;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_den = 1'b0;
  logic        i_ph_en = 1'b0;
  logic        o_tx_start;
  logic [27:0] o_pps_ofs;
  logic [3:0]  o_ch_mask;
  logic [7:0]  o_rpt_div;
  logic        o_resync, o_ack, o_err, o_busy;

  always #5 clk = ~clk;

  cmd_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .RESYNC_CYC(RESYNC_CYC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_den(i_rx_den),
    .i_ph_en(i_ph_en), .o_tx_start(o_tx_start), .o_pps_ofs(o_pps_ofs),
    .o_ch_mask(o_ch_mask), .o_rpt_div(o_rpt_div), .o_resync(o_resync),
    .o_ack(o_ack), .o_err(o_err), .o_busy(o_busy)
  );

  int checks = 0, errors = 0;
  int n_ack, n_err, n_tx, n_busy, n_rs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_ack = 0; n_err = 0; n_tx = 0; n_busy = 0; n_rs = 0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_ack)      n_ack++;
    if (o_err)      n_err++;
    if (o_tx_start) n_tx++;
    if (o_busy)     n_busy++;
    if (o_resync)   n_rs++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_den  = 1'b1;
    tick();
    i_rx_den  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic do_reset();
    i_rx_den = 1'b0;
    i_ph_en  = 1'b0;
    i_rst    = 1'b1;
    tick();
    tick();
    i_rst    = 1'b0;
  endtask

  // ---------------- table of single frames ----------------
  typedef struct {
    string       body;
    logic [15:0] tail;     // terminator bytes, high byte first, 0 = none
    int          n_ack;
    int          n_err;
    bit          busy;
    logic [27:0] ofs;
    logic [3:0]  mask;
    logic [7:0]  div;
  } vec_t;

  vec_t tbl[12];

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  logic [7:0]  fb[$];
  logic [27:0] m_ofs;
  logic [3:0]  m_mask;
  logic [7:0]  m_div;
  int          m_k, m_rs;
  bit          m_ack, m_err;

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (up(c) >= "A" && up(c) <= "F");
  endfunction

  function automatic logic [3:0] hval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - "0");
    return 4'(up(c) - "A" + 8'd10);
  endfunction

  // Frame-level judgement: collect bytes until a terminator, then decide.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0]  c;
    int          n;
    bit          ok;
    logic [27:0] v;
    if (b != 8'h0D && b != 8'h0A) begin
      fb.push_back(b);
      return;
    end
    if (fb.size() == 0) return;
    c = up(fb[0]); ok = 1'b1; v = '0; n = 0;
    case (c)
      "O": n = 7;
      "M": n = 1;
      "R": n = 2;
      "Z": n = 0;
      default: ok = 1'b0;
    endcase
    if (fb.size() - 1 != n) ok = 1'b0;
    for (int i = 1; i < fb.size(); i++) begin
      if (!is_hex(fb[i])) ok = 1'b0;
      else v = {v[23:0], hval(fb[i])};
    end
    fb.delete();
    if (!ok) begin
      m_err = 1'b1;
      return;
    end
    m_ack = 1'b1;
    case (c)
      "O": m_ofs  = v;
      "M": m_mask = v[3:0];
      "R": begin m_div = v[7:0]; m_k = 0; end
      default: m_rs = RESYNC_CYC;
    endcase
  endtask

  task automatic gen_frame();
    string      hx = "0123456789abcdefABCDEF";
    string      lt = "OMRZomrz";
    int         li = $urandom_range(0, 7);
    int         kind = $urandom_range(0, 9);
    int         n;
    logic [7:0] term = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
    logic [7:0] bad;
    case (li % 4)
      0: n = 7;
      1: n = 1;
      2: n = 2;
      default: n = 0;
    endcase
    if (kind == 9) begin
      q.push_back(term);
      return;
    end
    if (kind == 8) begin
      bad = ($urandom_range(0, 1) != 0) ? 8'h51 : 8'h35;   // 'Q' or '5'
      q.push_back(bad);
    end else begin
      q.push_back(lt[li]);
    end
    if (kind == 6) n = (n == 0) ? 1 : n + (($urandom_range(0, 1) != 0) ? 1 : -1);
    for (int i = 0; i < n; i++) q.push_back(hx[$urandom_range(0, 21)]);
    if (kind == 7) begin
      bad = ($urandom_range(0, 1) != 0) ? 8'h47 : 8'h78;   // 'G' or 'x'
      q.push_back(bad);
    end
    q.push_back(term);
  endtask

  initial begin
    int err_at;
    int gap;
    bit e_tx, e_rs;

    tbl[0]  = '{"O00186A0", 16'h000D, 1, 0, 1'b1, 28'h00186A0, 4'hF, 8'h00};
    tbl[1]  = '{"m5",       16'h000A, 1, 0, 1'b1, 28'h00186A0, 4'h5, 8'h00};
    tbl[2]  = '{"R03",      16'h000D, 1, 0, 1'b1, 28'h00186A0, 4'h5, 8'h03};
    tbl[3]  = '{"O12",      16'h000D, 0, 1, 1'b1, 28'h00186A0, 4'h5, 8'h03};
    tbl[4]  = '{"M1G",      16'h000D, 0, 1, 1'b1, 28'h00186A0, 4'h5, 8'h03};
    tbl[5]  = '{"Q",        16'h000D, 0, 1, 1'b1, 28'h00186A0, 4'h5, 8'h03};
    tbl[6]  = '{"",         16'h0D0A, 0, 0, 1'b0, 28'h00186A0, 4'h5, 8'h03};
    tbl[7]  = '{"oABCDEF1", 16'h000D, 1, 0, 1'b1, 28'hABCDEF1, 4'h5, 8'h03};
    tbl[8]  = '{"M12",      16'h000D, 0, 1, 1'b1, 28'hABCDEF1, 4'h5, 8'h03};
    tbl[9]  = '{"rFf",      16'h000A, 1, 0, 1'b1, 28'hABCDEF1, 4'h5, 8'hFF};
    tbl[10] = '{"Mf",       16'h000D, 1, 0, 1'b1, 28'hABCDEF1, 4'hF, 8'hFF};
    tbl[11] = '{"O",        16'h000D, 0, 1, 1'b1, 28'hABCDEF1, 4'hF, 8'hFF};

    // ---- reset state ----
    do_reset();
    chk("rst_ofs", o_pps_ofs, 28'h0);
    chk("rst_mask", o_ch_mask, 4'hF);
    chk("rst_div", o_rpt_div, 8'h0);
    chk("rst_resync", o_resync, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ack", o_ack, 1'b0);

    // ---- frame table ----
    for (int t = 0; t < 12; t++) begin
      clr_cnt();
      send_str(tbl[t].body, 3);
      if (tbl[t].tail[15:8] != 8'h00) send_byte(tbl[t].tail[15:8], 3);
      send_byte(tbl[t].tail[7:0], 4);
      chk($sformatf("tbl%0d_ack", t), n_ack, tbl[t].n_ack);
      chk($sformatf("tbl%0d_err", t), n_err, tbl[t].n_err);
      chk($sformatf("tbl%0d_busy", t), n_busy > 0, tbl[t].busy);
      chk($sformatf("tbl%0d_ofs", t), o_pps_ofs, tbl[t].ofs);
      chk($sformatf("tbl%0d_mask", t), o_ch_mask, tbl[t].mask);
      chk($sformatf("tbl%0d_div", t), o_rpt_div, tbl[t].div);
    end

    // ---- ack latency: register and o_ack one edge after the terminator ----
    send_str("O1234567", 3);
    send_byte(8'h0D, 0);
    chk("lat_ack", o_ack, 1'b1);
    chk("lat_ofs", o_pps_ofs, 28'h1234567);
    chk("lat_busy_apply", o_busy, 1'b1);
    tick();
    chk("lat_ack_gone", o_ack, 1'b0);
    chk("lat_busy_idle", o_busy, 1'b0);

    // ---- report scheduler: div 3 -> strobes 1 and 5 of 8 ----
    send_str("R03", 3);
    send_byte(8'h0D, 3);
    for (int s = 1; s <= 8; s++) begin
      i_ph_en = 1'b1;
      tick();
      i_ph_en = 1'b0;
      chk($sformatf("rpt_strobe%0d", s), o_tx_start, (s == 1 || s == 5));
      tick();
      chk($sformatf("rpt_strobe%0d_gone", s), o_tx_start, 1'b0);
      tick();
    end

    // ---- inter-byte timeout ----
    clr_cnt();
    send_byte("O", 3);
    send_byte("1", 3);
    send_byte("2", 0);
    err_at = -1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (o_err && err_at < 0) err_at = k;
    end
    chk("timeout_cycle", err_at, 100);
    chk("timeout_err_once", n_err, 1);
    chk("timeout_idle", o_busy, 1'b0);
    clr_cnt();
    send_str("M3", 3);
    send_byte(8'h0D, 4);
    chk("after_timeout_ack", n_ack, 1);
    chk("after_timeout_mask", o_ch_mask, 4'h3);

    // ---- resync window restarted after 10 cycles -> 30 cycles high ----
    do_reset();
    clr_cnt();
    send_byte("Z", 3);
    send_byte(8'h0D, 4);
    send_byte("Z", 4);
    send_byte(8'h0D, 0);
    repeat (40) tick();
    chk("resync_len", n_rs, 30);
    chk("resync_end", o_resync, 1'b0);

    // ---- reset mid-frame ----
    send_str("R05", 3); send_byte(8'h0D, 3);
    send_str("O0000042", 3); send_byte(8'h0D, 3);
    send_byte("Z", 3); send_byte(8'h0D, 3);
    send_str("O12", 3);
    i_rst = 1'b1;
    tick();
    chk("mrst_ofs", o_pps_ofs, 28'h0);
    chk("mrst_mask", o_ch_mask, 4'hF);
    chk("mrst_div", o_rpt_div, 8'h0);
    chk("mrst_resync", o_resync, 1'b0);
    chk("mrst_busy", o_busy, 1'b0);
    chk("mrst_pulses", {o_ack, o_err, o_tx_start}, 3'b000);
    i_rst = 1'b0;
    clr_cnt();
    repeat (150) tick();
    chk("mrst_no_err", n_err, 0);

    // ---- randomized run against the frame-level model ----
    do_reset();
    q.delete(); fb.delete();
    m_ofs = 28'h0; m_mask = 4'hF; m_div = 8'h0; m_k = 0; m_rs = 0;
    gap = 2;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (q.size() == 0) gen_frame();
      if (gap == 0) begin
        i_rx_den  = 1'b1;
        i_rx_data = q.pop_front();
        gap = $urandom_range(2, 6);
      end else begin
        i_rx_den = 1'b0;
        gap--;
      end
      i_ph_en = ($urandom_range(0, 3) == 0);
      m_ack = 1'b0; m_err = 1'b0; e_tx = 1'b0;
      // Strobe decision uses the pre-write phase; an 'R' write then rephases.
      if (i_ph_en) begin
        e_tx = ((m_k % (int'(m_div) + 1)) == 0);
        m_k++;
      end
      if (i_rx_den) model_byte(i_rx_data);
      e_rs = (m_rs > 0);
      if (m_rs > 0) m_rs--;
      tick();
      chk("rnd_ack", o_ack, m_ack);
      chk("rnd_err", o_err, m_err);
      chk("rnd_tx", o_tx_start, e_tx);
      chk("rnd_ofs", o_pps_ofs, m_ofs);
      chk("rnd_mask", o_ch_mask, m_mask);
      chk("rnd_div", o_rpt_div, m_div);
      chk("rnd_resync", o_resync, e_rs);
      chk("rnd_busy", o_busy, (fb.size() > 0) || m_ack);
    end
    i_rx_den = 1'b0;
    i_ph_en  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
